// File: rtl/qspi_xfer_seq.sv
// qspi_xfer_seq: QSPI command-header sequencer.
// Issues one single-IO header per request: a command byte, optional
// address bytes (MSB first), then optional dummy clocks. It drives the
// 8-bit command shift register through load/shift strobes and generates
// the mode-0 sclk and the chip select.
//
// Ports:
//   clk, rst_n          HCLK and asynchronous active-low reset
//   i_start             request pulse, sampled only while o_busy=0
//   i_cmd, i_addr,      request payload, captured when i_start is accepted
//   i_addr_en,
//   i_dummy_cycles
//   o_busy              transfer in progress, incl. chip-select idle time
//   o_done              one-cycle pulse in the cycle cs_n returns high
//   o_cs_n, o_sclk      flash chip select (active low) and SPI clock
//   o_sr_data           byte presented to the shift register
//   o_sr_load           load strobe to the shift register
//   o_sr_shift_en       shift strobe to the shift register
module qspi_xfer_seq #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned ADDR_BYTES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_cmd,
   input  logic [31:0] i_addr,
   input  logic        i_addr_en,
   input  logic [3:0]  i_dummy_cycles,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_cs_n,
   output logic        o_sclk,
   output logic [7:0]  o_sr_data,
   output logic        o_sr_load,
   output logic        o_sr_shift_en
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_SHIFT  = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;
   localparam logic [2:0] S_CSIDLE = 3'd5;

   localparam int unsigned DIV_W      = 8;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [2:0] LAST_ADDR_IDX  = 3'(ADDR_BYTES);
   // Left-justify the used address bytes so the next byte is always [31:24].
   localparam int unsigned ADDR_ALIGN = 8 * (4 - ADDR_BYTES);

   logic [2:0]       r_state,     w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt,   w_div_nxt;
   logic [2:0]       r_bit_cnt,   w_bit_nxt;
   logic [2:0]       r_byte_cnt,  w_byte_nxt;
   logic [3:0]       r_dcnt,      w_dcnt_nxt;
   logic [31:0]      r_addr,      w_addr_nxt;
   logic             r_addr_en,   w_addr_en_nxt;
   logic [3:0]       r_dummy,     w_dummy_nxt;
   logic             r_busy,      w_busy_nxt;
   logic             r_done,      w_done_nxt;
   logic             r_cs_n,      w_cs_n_nxt;
   logic             r_sclk,      w_sclk_nxt;
   logic [7:0]       r_sr_data,   w_sr_data_nxt;
   logic             r_sr_load,   w_sr_load_nxt;
   logic             r_sr_shift,  w_sr_shift_nxt;

   logic             w_tick;
   logic [2:0]       w_last_byte;

   assign w_tick      = (r_div_cnt == DIV_LAST);
   assign w_last_byte = r_addr_en ? LAST_ADDR_IDX : 3'd0;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_dcnt     <= '0;
         r_addr     <= '0;
         r_addr_en  <= 1'b0;
         r_dummy    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sclk     <= 1'b0;
         r_sr_data  <= '0;
         r_sr_load  <= 1'b0;
         r_sr_shift <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div_cnt  <= w_div_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_byte_cnt <= w_byte_nxt;
         r_dcnt     <= w_dcnt_nxt;
         r_addr     <= w_addr_nxt;
         r_addr_en  <= w_addr_en_nxt;
         r_dummy    <= w_dummy_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_sclk     <= w_sclk_nxt;
         r_sr_data  <= w_sr_data_nxt;
         r_sr_load  <= w_sr_load_nxt;
         r_sr_shift <= w_sr_shift_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_div_nxt      = '0;
      w_bit_nxt      = r_bit_cnt;
      w_byte_nxt     = r_byte_cnt;
      w_dcnt_nxt     = r_dcnt;
      w_addr_nxt     = r_addr;
      w_addr_en_nxt  = r_addr_en;
      w_dummy_nxt    = r_dummy;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_cs_n_nxt     = r_cs_n;
      w_sclk_nxt     = r_sclk;
      w_sr_data_nxt  = r_sr_data;
      w_sr_load_nxt  = 1'b0;
      w_sr_shift_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_addr_nxt    = i_addr << ADDR_ALIGN;
               w_addr_en_nxt = i_addr_en;
               w_dummy_nxt   = i_dummy_cycles;
               w_cs_n_nxt    = 1'b0;
               w_busy_nxt    = 1'b1;
               w_sclk_nxt    = 1'b0;
               w_sr_load_nxt = 1'b1;
               w_sr_data_nxt = i_cmd;
               w_state_nxt   = S_SETUP;
            end
         end
         S_SETUP: begin
            if (w_tick) begin
               w_bit_nxt   = '0;
               w_byte_nxt  = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               w_sclk_nxt = ~r_sclk;
               // All strobe/phase decisions happen on the falling sclk edge.
               if (r_sclk) begin
                  if (r_bit_cnt != 3'd7) begin
                     w_sr_shift_nxt = 1'b1;
                     w_bit_nxt      = r_bit_cnt + 3'd1;
                  end else if (r_byte_cnt < w_last_byte) begin
                     w_sr_load_nxt = 1'b1;
                     w_sr_data_nxt = r_addr[31:24];
                     w_addr_nxt    = {r_addr[23:0], 8'h00};
                     w_byte_nxt    = r_byte_cnt + 3'd1;
                     w_bit_nxt     = '0;
                  end else if (r_dummy != 4'd0) begin
                     w_dcnt_nxt  = '0;
                     w_state_nxt = S_DUMMY;
                  end else begin
                     w_state_nxt = S_HOLD;
                  end
               end
            end
         end
         S_DUMMY: begin
            if (w_tick) begin
               w_sclk_nxt = ~r_sclk;
               if (r_sclk) begin
                  if (r_dcnt == r_dummy - 4'd1) begin
                     w_state_nxt = S_HOLD;
                  end else begin
                     w_dcnt_nxt = r_dcnt + 4'd1;
                  end
               end
            end
         end
         S_HOLD: begin
            if (w_tick) begin
               w_cs_n_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_CSIDLE;
            end
         end
         S_CSIDLE: begin
            if (w_tick) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Half-period counter restarts on every state entry and idles at zero.
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || w_tick) begin
         w_div_nxt = '0;
      end else begin
         w_div_nxt = r_div_cnt + DIV_W'(1);
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_cs_n        = r_cs_n;
   assign o_sclk        = r_sclk;
   assign o_sr_data     = r_sr_data;
   assign o_sr_load     = r_sr_load;
   assign o_sr_shift_en = r_sr_shift;

endmodule

// File: tb/tb_qspi_xfer_seq.sv
// Bench for qspi_xfer_seq: two instances (D=2/3-byte address and
// D=4/4-byte address), a table of transactions with expected per-transfer
// counts, and a scoreboard of expected load bytes and MOSI bytes.
`timescale 1ns/1ps
module tb_qspi_xfer_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start   [2];
   logic [7:0] cmd     [2];
   logic [31:0] addr   [2];
   logic       addr_en [2];
   logic [3:0] dummy   [2];
   logic       busy    [2];
   logic       done    [2];
   logic       cs_n    [2];
   logic       sclk    [2];
   logic [7:0] sr_data [2];
   logic       sr_load [2];
   logic       sr_shift[2];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int cs_low;
      int rises;
      int loads;
      int shifts;
      int nbytes;
   } txn_t;

   typedef struct {
      int          sel;
      logic [7:0]  cmd;
      logic [31:0] addr;
      bit          addr_en;
      logic [3:0]  dummy;
      bit          inj_mid;
      bit          inj_cs;
      int          cs_low;
      int          rises;
      int          loads;
      int          shifts;
   } vec_t;

   txn_t       q_txn [2][$];
   logic [7:0] q_load[2][$];
   logic [7:0] q_mosi[2][$];

   always #5 clk = ~clk;

   qspi_xfer_seq #(.CLK_DIV(2), .ADDR_BYTES(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_cmd(cmd[0]),
      .i_addr(addr[0]), .i_addr_en(addr_en[0]), .i_dummy_cycles(dummy[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_cs_n(cs_n[0]), .o_sclk(sclk[0]),
      .o_sr_data(sr_data[0]), .o_sr_load(sr_load[0]), .o_sr_shift_en(sr_shift[0])
   );

   qspi_xfer_seq #(.CLK_DIV(4), .ADDR_BYTES(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_cmd(cmd[1]),
      .i_addr(addr[1]), .i_addr_en(addr_en[1]), .i_dummy_cycles(dummy[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_cs_n(cs_n[1]), .o_sclk(sclk[1]),
      .o_sr_data(sr_data[1]), .o_sr_load(sr_load[1]), .o_sr_shift_en(sr_shift[1])
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      n_checks++;
      $display("FAIL %s", nm);
   endtask

   // Per-instance monitor: strobes, MOSI reconstruction, phase lengths, counts.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int D = (g == 0) ? 2 : 4;
      int cs_low_cnt, rise_cnt, load_cnt, shift_cnt, phase_len, bc, nbits;
      bit phase_valid;
      logic prev_sclk, prev_cs_n;
      logic [7:0] model, bitacc, exp_b;
      txn_t t;

      initial begin
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               q_txn[g].delete(); q_load[g].delete(); q_mosi[g].delete();
               cs_low_cnt = 0; rise_cnt = 0; load_cnt = 0; shift_cnt = 0;
               phase_len = 0; phase_valid = 1'b0; bc = 0; nbits = 0;
               prev_sclk = 1'b0; prev_cs_n = 1'b1; model = '0; bitacc = '0;
            end else begin
               if (bc > 0) begin
                  if (bc == D - 1) chk($sformatf("dut%0d busy_before_idle", g), longint'(busy[g]), 1);
                  if (bc == D) chk($sformatf("dut%0d busy_fall_after_done", g), longint'(busy[g]), 0);
                  bc = (bc >= D) ? 0 : bc + 1;
               end
               if (sr_load[g] && sr_shift[g]) fail($sformatf("dut%0d load_shift_overlap", g));
               if (sr_load[g]) begin
                  load_cnt++;
                  if (q_load[g].size() == 0) fail($sformatf("dut%0d extra_load data=0x%0h", g, sr_data[g]));
                  else begin
                     exp_b = q_load[g].pop_front();
                     chk($sformatf("dut%0d load_data", g), longint'(sr_data[g]), longint'(exp_b));
                  end
               end
               if (sr_shift[g]) shift_cnt++;
               if (!cs_n[g]) begin
                  cs_low_cnt++;
                  if (sclk[g] != prev_sclk) begin
                     if (phase_valid) chk($sformatf("dut%0d sclk_phase_len", g), phase_len, D);
                     phase_valid = 1'b1;
                     phase_len = 1;
                  end else begin
                     phase_len++;
                  end
               end else begin
                  phase_valid = 1'b0;
               end
               if (sclk[g] && !prev_sclk) begin
                  if (q_txn[g].size() > 0 && rise_cnt < 8 * q_txn[g][0].nbytes) begin
                     bitacc = {bitacc[6:0], model[7]};
                     nbits++;
                     if (nbits == 8) begin
                        nbits = 0;
                        if (q_mosi[g].size() == 0) fail($sformatf("dut%0d extra_mosi_byte", g));
                        else begin
                           exp_b = q_mosi[g].pop_front();
                           chk($sformatf("dut%0d mosi_byte", g), longint'(bitacc), longint'(exp_b));
                        end
                     end
                  end
                  rise_cnt++;
               end
               // Shift register state after the coming clk edge.
               if (sr_load[g]) model = sr_data[g];
               else if (sr_shift[g]) model = {model[6:0], 1'b0};
               if (!prev_cs_n && cs_n[g])
                  chk($sformatf("dut%0d done_at_cs_rise", g), longint'(done[g]), 1);
               if (done[g]) begin
                  if (q_txn[g].size() == 0) fail($sformatf("dut%0d stray_done", g));
                  else begin
                     t = q_txn[g].pop_front();
                     chk($sformatf("dut%0d cs_low_cycles", g), cs_low_cnt, t.cs_low);
                     chk($sformatf("dut%0d sclk_rises", g), rise_cnt, t.rises);
                     chk($sformatf("dut%0d load_count", g), load_cnt, t.loads);
                     chk($sformatf("dut%0d shift_count", g), shift_cnt, t.shifts);
                  end
                  cs_low_cnt = 0; rise_cnt = 0; load_cnt = 0; shift_cnt = 0; nbits = 0;
                  bc = 1;
               end
               prev_sclk = sclk[g];
               prev_cs_n = cs_n[g];
            end
         end
      end
   end

   // Queue the expected bytes and counts for one request on instance g.
   task automatic push_exp(input vec_t v);
      int g, ab, nb;
      logic [7:0] b;
      g  = v.sel;
      ab = (g == 0) ? 3 : 4;
      nb = v.addr_en ? 1 + ab : 1;
      q_txn[g].push_back('{v.cs_low, v.rises, v.loads, v.shifts, nb});
      q_load[g].push_back(v.cmd);
      q_mosi[g].push_back(v.cmd);
      if (v.addr_en) begin
         for (int i = ab - 1; i >= 0; i--) begin
            b = v.addr[8*i +: 8];
            q_load[g].push_back(b);
            q_mosi[g].push_back(b);
         end
      end
   endtask

   // Wait for idle, issue the request, optionally poke start while busy.
   task automatic run_txn(input vec_t v, input bit wait_done);
      int g, n;
      g = v.sel;
      @(negedge clk);
      n = 0;
      while (busy[g] !== 1'b0) begin
         if (n >= 3000) begin fail($sformatf("dut%0d idle_timeout", g)); return; end
         @(negedge clk);
         n++;
      end
      push_exp(v);
      cmd[g] = v.cmd; addr[g] = v.addr; addr_en[g] = v.addr_en; dummy[g] = v.dummy;
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      chk($sformatf("dut%0d accept_busy", g), longint'(busy[g]), 1);
      chk($sformatf("dut%0d accept_cs_n", g), longint'(cs_n[g]), 0);
      if (v.inj_mid) begin
         repeat (20) @(negedge clk);
         cmd[g] = 8'h05; start[g] = 1'b1;
         @(negedge clk);
         start[g] = 1'b0;
      end
      if (!wait_done) return;
      n = 0;
      while (done[g] !== 1'b1) begin
         if (n >= 6000) begin fail($sformatf("dut%0d done_timeout", g)); return; end
         @(negedge clk);
         n++;
      end
      if (v.inj_cs) begin
         cmd[g] = 8'h05; start[g] = 1'b1;
         @(negedge clk);
         start[g] = 1'b0;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   vec_t vecs[7];
   vec_t vr;

   initial begin
      vecs[0] = '{0, 8'h9F, 32'h0000_0000, 1'b0, 4'd0,  1'b0, 1'b1, 36,  8,  1, 7};
      vecs[1] = '{0, 8'h0B, 32'h0012_3456, 1'b1, 4'd8,  1'b1, 1'b0, 164, 40, 4, 28};
      vecs[2] = '{1, 8'h0B, 32'hDEAD_BEEF, 1'b1, 4'd0,  1'b0, 1'b0, 328, 40, 5, 35};
      vecs[3] = '{0, 8'h03, 32'h00AB_CDEF, 1'b1, 4'd0,  1'b0, 1'b1, 132, 32, 4, 28};
      vecs[4] = '{1, 8'h6B, 32'h1234_5678, 1'b1, 4'd15, 1'b1, 1'b1, 448, 55, 5, 35};
      vecs[5] = '{1, 8'hA5, 32'hFFFF_FFFF, 1'b0, 4'd1,  1'b0, 1'b0, 80,  9,  1, 7};
      vecs[6] = '{0, 8'h3C, 32'h0000_0000, 1'b0, 4'd15, 1'b0, 1'b0, 96,  23, 1, 7};

      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0; cmd[g] = '0; addr[g] = '0; addr_en[g] = 1'b0; dummy[g] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("dut%0d rst_cs_n", g), longint'(cs_n[g]), 1);
         chk($sformatf("dut%0d rst_sclk", g), longint'(sclk[g]), 0);
         chk($sformatf("dut%0d rst_busy", g), longint'(busy[g]), 0);
         chk($sformatf("dut%0d rst_done", g), longint'(done[g]), 0);
         chk($sformatf("dut%0d rst_sr_load", g), longint'(sr_load[g]), 0);
         chk($sformatf("dut%0d rst_sr_shift", g), longint'(sr_shift[g]), 0);
         chk($sformatf("dut%0d rst_sr_data", g), longint'(sr_data[g]), 0);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("dut%0d idle_busy", g), longint'(busy[g]), 0);
         chk($sformatf("dut%0d idle_cs_n", g), longint'(cs_n[g]), 1);
      end

      for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b1);

      // Reset in the middle of the address phase.
      vr = '{0, 8'h0B, 32'h00C0_FFEE, 1'b1, 4'd2, 1'b0, 1'b0, 140, 34, 4, 28};
      run_txn(vr, 1'b0);
      repeat (30) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("dut0 midrst_cs_n", longint'(cs_n[0]), 1);
      chk("dut0 midrst_sclk", longint'(sclk[0]), 0);
      chk("dut0 midrst_busy", longint'(busy[0]), 0);
      chk("dut0 midrst_done", longint'(done[0]), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("dut0 post_rst_cs_n", longint'(cs_n[0]), 1);
      run_txn(vr, 1'b1);

      repeat (10) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("dut%0d pending_txn", g), q_txn[g].size(), 0);
         chk($sformatf("dut%0d pending_loads", g), q_load[g].size(), 0);
         chk($sformatf("dut%0d final_busy", g), longint'(busy[g]), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
